// File: rtl/tile_interact_pkg.sv
// Shared tile-resource ID ranges, engine state encoding and tile class type
// for tile_interact_engine and tile_classify.
package tile_interact_pkg;

  localparam logic [15:0] TILE_GROUND_0   = 16'h0000;
  localparam logic [15:0] TILE_WALL_LO    = 16'h0010;
  localparam logic [15:0] TILE_WALL_HI    = 16'h001F;
  localparam logic [15:0] TILE_KEY_BASE   = 16'h0020;
  localparam logic [15:0] TILE_POTION_LO  = 16'h0030;
  localparam logic [15:0] TILE_POTION_HI  = 16'h003F;
  localparam logic [15:0] TILE_GEM_LO     = 16'h0040;
  localparam logic [15:0] TILE_GEM_HI     = 16'h004F;
  localparam logic [15:0] TILE_DOOR_BASE  = 16'h0050;
  localparam logic [15:0] TILE_UPSTAIR    = 16'h0060;
  localparam logic [15:0] TILE_DOWNSTAIR  = 16'h0061;
  localparam logic [15:0] TILE_MON_LO     = 16'h0100;
  localparam logic [15:0] TILE_MON_HI     = 16'h01FF;

  // Health cost of a monster when the combat engine is not built.
  localparam int MON_COST = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EXEC  = 2'd1,
    S_FIGHT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic wall;
    logic key;
    logic potion;
    logic gem;
    logic door;
    logic monster;
    logic up;
    logic down;
    logic other;
  } tile_class_t;

endpackage

// File: rtl/tile_interact_engine_tile_classify.sv
// Combinational tile_id decoder: one-hot tile class plus key/door colour index.
module tile_classify
  import tile_interact_pkg::*;
#(
  parameter int KEY_TYPES = 4
) (
  input  logic [15:0]  tile_id,
  output tile_class_t  cls,
  output logic [7:0]   idx
);

  logic [15:0] key_off;
  logic [15:0] door_off;

  // Range decode; key and door blocks hold KEY_TYPES consecutive IDs each.
  always_comb begin
    key_off  = tile_id - TILE_KEY_BASE;
    door_off = tile_id - TILE_DOOR_BASE;
    cls      = '0;
    idx      = 8'd0;
    if (tile_id >= TILE_WALL_LO && tile_id <= TILE_WALL_HI) begin
      cls.wall = 1'b1;
    end else if (tile_id >= TILE_KEY_BASE && key_off < 16'(KEY_TYPES)) begin
      cls.key = 1'b1;
      idx     = key_off[7:0];
    end else if (tile_id >= TILE_POTION_LO && tile_id <= TILE_POTION_HI) begin
      cls.potion = 1'b1;
    end else if (tile_id >= TILE_GEM_LO && tile_id <= TILE_GEM_HI) begin
      cls.gem = 1'b1;
    end else if (tile_id >= TILE_DOOR_BASE && door_off < 16'(KEY_TYPES)) begin
      cls.door = 1'b1;
      idx      = door_off[7:0];
    end else if (tile_id == TILE_UPSTAIR) begin
      cls.up = 1'b1;
    end else if (tile_id == TILE_DOWNSTAIR) begin
      cls.down = 1'b1;
    end else if (tile_id >= TILE_MON_LO && tile_id <= TILE_MON_HI) begin
      cls.monster = 1'b1;
    end else begin
      cls.other = 1'b1;
    end
  end

endmodule

// File: rtl/tile_interact_engine.sv
// Registered, handshaked tile-interaction engine (IDLE/EXEC/FIGHT/DONE).
// Define INTERACT_COMBAT_EN to build iterative combat; otherwise monsters cost fixed health.
module tile_interact_engine
  import tile_interact_pkg::*;
#(
  parameter int KEY_TYPES   = 4,
  parameter int KEY_W       = 8,
  parameter int HP_W        = 16,
  parameter int STAT_W      = 8,
  parameter int FLOOR_W     = 16,
  parameter int POTION_HEAL = 5,
  parameter int MAX_ROUNDS  = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [3:0]                  pos_x,
  input  logic [3:0]                  pos_y,
  input  logic [3:0]                  player_x,
  input  logic [3:0]                  player_y,
  input  logic [15:0]                 tile_id,
  input  logic [FLOOR_W-1:0]          floor,
  input  logic [KEY_TYPES*KEY_W-1:0]  key_num,
  input  logic [HP_W-1:0]             health,
  input  logic [STAT_W-1:0]           atk,
  input  logic [STAT_W-1:0]           def,
  input  logic [STAT_W-1:0]           mon_hp,
  input  logic [STAT_W-1:0]           mon_atk,
  input  logic [STAT_W-1:0]           mon_def,
  input  logic [3:0]                  up_x,
  input  logic [3:0]                  up_y,
  input  logic [3:0]                  down_x,
  input  logic [3:0]                  down_y,
  output logic                        res_valid,
  output logic                        blocked,
  output logic [3:0]                  goto_x,
  output logic [3:0]                  goto_y,
  output logic [FLOOR_W-1:0]          floor_out,
  output logic [KEY_TYPES*KEY_W-1:0]  key_num_out,
  output logic [HP_W-1:0]             health_out,
  output logic [15:0]                 new_tile_id
);

  localparam int KN_W = KEY_TYPES * KEY_W;

  state_t             state;
  logic [3:0]         pos_x_r, pos_y_r, player_x_r, player_y_r;
  logic [3:0]         up_x_r, up_y_r, down_x_r, down_y_r;
  logic [15:0]        tile_r;
  logic [FLOOR_W-1:0] floor_r;
  logic [KN_W-1:0]    key_r;
  logic [HP_W-1:0]    health_r;

  tile_class_t        cls;
  logic [7:0]         kidx;

  logic               ex_blocked, ex_fight;
  logic [3:0]         ex_gx, ex_gy;
  logic [FLOOR_W-1:0] ex_floor;
  logic [KN_W-1:0]    ex_keys;
  logic [HP_W-1:0]    ex_health;
  logic [15:0]        ex_tile;
  logic [KEY_W-1:0]   sel_key, new_key;
  logic [KEY_W:0]     key_inc;
  logic [HP_W:0]      hp_inc;
  logic [FLOOR_W:0]   fl_inc;

  // Results are staged here and only become visible in DONE.
  logic               stg_blocked;
  logic [3:0]         stg_gx, stg_gy;
  logic [FLOOR_W-1:0] stg_floor;
  logic [KN_W-1:0]    stg_keys;
  logic [HP_W-1:0]    stg_health;
  logic [15:0]        stg_tile;

  assign req_ready = (state == S_IDLE);

  tile_classify #(.KEY_TYPES(KEY_TYPES)) u_classify (
    .tile_id (tile_r),
    .cls     (cls),
    .idx     (kidx)
  );

`ifdef INTERACT_COMBAT_EN
  localparam int RND_W = $clog2(MAX_ROUNDS + 1);
  logic [STAT_W-1:0] atk_r, def_r, mon_hp_r, mon_atk_r, mon_def_r;
  logic [STAT_W-1:0] dm, dp, dm_r, dp_r, mhp_r, mhp_next;
  logic [HP_W-1:0]   hp_r, hp_next;
  logic [RND_W-1:0]  rounds_r, rounds_next;
  logic              unused_sink;
  assign unused_sink = cls.other;

  // Damage per round and next combat round values; saturating at zero.
  always_comb begin
    dm          = (atk_r > mon_def_r) ? (atk_r - mon_def_r) : '0;
    dp          = (mon_atk_r > def_r) ? (mon_atk_r - def_r) : '0;
    mhp_next    = (mhp_r > dm_r) ? (mhp_r - dm_r) : '0;
    hp_next     = (hp_r > HP_W'(dp_r)) ? (hp_r - HP_W'(dp_r)) : '0;
    rounds_next = rounds_r + RND_W'(1);
  end
`else
  logic unused_sink;
  assign unused_sink = ^{cls.other, atk, def, mon_hp, mon_atk, mon_def};
`endif

  // Single-step resolution of the captured request.
  always_comb begin
    ex_blocked = 1'b0;
    ex_fight   = 1'b0;
    ex_gx      = pos_x_r;
    ex_gy      = pos_y_r;
    ex_floor   = floor_r;
    ex_health  = health_r;
    ex_tile    = tile_r;
    sel_key    = '0;
    for (int i = 0; i < KEY_TYPES; i++) begin
      sel_key = (kidx == 8'(i)) ? key_r[i*KEY_W +: KEY_W] : sel_key;
    end
    new_key = sel_key;
    key_inc = {1'b0, sel_key} + (KEY_W+1)'(1);
    hp_inc  = {1'b0, health_r} + (HP_W+1)'(POTION_HEAL);
    fl_inc  = {1'b0, floor_r} + (FLOOR_W+1)'(1);
    if (cls.wall) begin
      ex_blocked = 1'b1;
    end else if (cls.key) begin
      new_key = key_inc[KEY_W] ? '1 : key_inc[KEY_W-1:0];
      ex_tile = TILE_GROUND_0;
    end else if (cls.potion || cls.gem) begin
      ex_health = hp_inc[HP_W] ? '1 : hp_inc[HP_W-1:0];
      ex_tile   = TILE_GROUND_0;
    end else if (cls.door) begin
      if (sel_key != '0) begin
        new_key = sel_key - KEY_W'(1);
        ex_tile = TILE_GROUND_0;
      end else begin
        ex_blocked = 1'b1;
      end
    end else if (cls.up) begin
      if (fl_inc[FLOOR_W]) begin
        ex_blocked = 1'b1;
      end else begin
        ex_gx    = up_x_r;
        ex_gy    = up_y_r;
        ex_floor = fl_inc[FLOOR_W-1:0];
      end
    end else if (cls.down) begin
      if (floor_r == '0) begin
        ex_blocked = 1'b1;
      end else begin
        ex_gx    = down_x_r;
        ex_gy    = down_y_r;
        ex_floor = floor_r - FLOOR_W'(1);
      end
    end else if (cls.monster) begin
`ifdef INTERACT_COMBAT_EN
      // Preload the losing result; a win overwrites it from FIGHT.
      ex_fight   = 1'b1;
      ex_blocked = 1'b1;
`else
      if (health_r > HP_W'(MON_COST)) begin
        ex_health = health_r - HP_W'(MON_COST);
        ex_tile   = TILE_GROUND_0;
      end else begin
        ex_blocked = 1'b1;
      end
`endif
    end else begin
      ex_blocked = 1'b0;
    end
    if (ex_blocked) begin
      ex_gx = player_x_r;
      ex_gy = player_y_r;
    end else begin
      ex_gx = ex_gx;
    end
    for (int i = 0; i < KEY_TYPES; i++) begin
      ex_keys[i*KEY_W +: KEY_W] = (kidx == 8'(i)) ? new_key : key_r[i*KEY_W +: KEY_W];
    end
  end

  // Engine FSM with captured request, staged results and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      pos_x_r     <= 4'd0;  pos_y_r    <= 4'd0;
      player_x_r  <= 4'd0;  player_y_r <= 4'd0;
      up_x_r      <= 4'd0;  up_y_r     <= 4'd0;
      down_x_r    <= 4'd0;  down_y_r   <= 4'd0;
      tile_r      <= 16'd0; floor_r    <= '0;
      key_r       <= '0;    health_r   <= '0;
      stg_blocked <= 1'b0;  stg_gx     <= 4'd0; stg_gy <= 4'd0;
      stg_floor   <= '0;    stg_keys   <= '0;
      stg_health  <= '0;    stg_tile   <= 16'd0;
      res_valid   <= 1'b0;  blocked    <= 1'b0;
      goto_x      <= 4'd0;  goto_y     <= 4'd0;
      floor_out   <= '0;    key_num_out <= '0;
      health_out  <= '0;    new_tile_id <= 16'd0;
`ifdef INTERACT_COMBAT_EN
      atk_r <= '0; def_r <= '0; mon_hp_r <= '0; mon_atk_r <= '0; mon_def_r <= '0;
      dm_r  <= '0; dp_r  <= '0; mhp_r    <= '0; hp_r      <= '0; rounds_r  <= '0;
`endif
    end else begin
      res_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            pos_x_r    <= pos_x;    pos_y_r    <= pos_y;
            player_x_r <= player_x; player_y_r <= player_y;
            up_x_r     <= up_x;     up_y_r     <= up_y;
            down_x_r   <= down_x;   down_y_r   <= down_y;
            tile_r     <= tile_id;  floor_r    <= floor;
            key_r      <= key_num;  health_r   <= health;
`ifdef INTERACT_COMBAT_EN
            atk_r <= atk; def_r <= def;
            mon_hp_r <= mon_hp; mon_atk_r <= mon_atk; mon_def_r <= mon_def;
`endif
            state <= S_EXEC;
          end else begin
            state <= S_IDLE;
          end
        end
        S_EXEC: begin
          stg_blocked <= ex_blocked; stg_gx   <= ex_gx;   stg_gy     <= ex_gy;
          stg_floor   <= ex_floor;   stg_keys <= ex_keys; stg_health <= ex_health;
          stg_tile    <= ex_tile;
`ifdef INTERACT_COMBAT_EN
          if (ex_fight && dm != '0) begin
            dm_r     <= dm;
            dp_r     <= dp;
            mhp_r    <= mon_hp_r;
            hp_r     <= health_r;
            rounds_r <= '0;
            state    <= S_FIGHT;
          end else begin
            state <= S_DONE;
          end
`else
          state <= S_DONE;
`endif
        end
        S_FIGHT: begin
`ifdef INTERACT_COMBAT_EN
          mhp_r    <= mhp_next;
          hp_r     <= hp_next;
          rounds_r <= rounds_next;
          if (mhp_next == '0) begin
            stg_blocked <= 1'b0;
            stg_health  <= hp_r;
            stg_tile    <= TILE_GROUND_0;
            stg_gx      <= pos_x_r;
            stg_gy      <= pos_y_r;
            state       <= S_DONE;
          end else if (hp_next == '0 || rounds_next == RND_W'(MAX_ROUNDS)) begin
            state <= S_DONE;
          end else begin
            state <= S_FIGHT;
          end
`else
          state <= S_IDLE;
`endif
        end
        S_DONE: begin
          res_valid   <= 1'b1;
          blocked     <= stg_blocked;
          goto_x      <= stg_gx;
          goto_y      <= stg_gy;
          floor_out   <= stg_floor;
          key_num_out <= stg_keys;
          health_out  <= stg_health;
          new_tile_id <= stg_tile;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_interact_engine.sv
// Scoreboard bench for tile_interact_engine: directed requests push expected results,
// a negedge monitor pops and compares on every res_valid strobe.
module tb_tile_interact_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid, req_ready;
  logic [3:0]  pos_x, pos_y, player_x, player_y, up_x, up_y, down_x, down_y;
  logic [15:0] tile_id, floor, health;
  logic [31:0] key_num;
  logic [7:0]  atk, def, mon_hp, mon_atk, mon_def;
  logic        res_valid, blocked;
  logic [3:0]  goto_x, goto_y;
  logic [15:0] floor_out, health_out, new_tile_id;
  logic [31:0] key_num_out;

  tile_interact_engine dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .pos_x(pos_x), .pos_y(pos_y), .player_x(player_x), .player_y(player_y),
    .tile_id(tile_id), .floor(floor), .key_num(key_num), .health(health),
    .atk(atk), .def(def), .mon_hp(mon_hp), .mon_atk(mon_atk), .mon_def(mon_def),
    .up_x(up_x), .up_y(up_y), .down_x(down_x), .down_y(down_y),
    .res_valid(res_valid), .blocked(blocked), .goto_x(goto_x), .goto_y(goto_y),
    .floor_out(floor_out), .key_num_out(key_num_out), .health_out(health_out),
    .new_tile_id(new_tile_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic        blocked;
    logic [3:0]  gx, gy;
    logic [15:0] fl;
    logic [31:0] keys;
    logic [15:0] hp;
    logic [15:0] tile;
    int          lat;
    int          start;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: compare every result strobe against the oldest expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (res_valid === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_res_valid", 64'd1, 64'd0);
      end else begin
        e = q.pop_front();
        check({e.tag, ".blocked"}, 64'(blocked), 64'(e.blocked));
        check({e.tag, ".goto_x"},  64'(goto_x), 64'(e.gx));
        check({e.tag, ".goto_y"},  64'(goto_y), 64'(e.gy));
        check({e.tag, ".floor"},   64'(floor_out), 64'(e.fl));
        check({e.tag, ".keys"},    64'(key_num_out), 64'(e.keys));
        check({e.tag, ".health"},  64'(health_out), 64'(e.hp));
        check({e.tag, ".tile"},    64'(new_tile_id), 64'(e.tile));
        check({e.tag, ".latency"}, 64'(cyc - e.start), 64'(e.lat));
      end
    end
  end

  task automatic set_defaults();
    req_valid = 1'b0;
    pos_x = 4'd5;    pos_y = 4'd6;   player_x = 4'd5; player_y = 4'd7;
    up_x = 4'd1;     up_y = 4'd2;    down_x = 4'd3;   down_y = 4'd4;
    tile_id = 16'h0000; floor = 16'd3; key_num = 32'h0; health = 16'd100;
    atk = 8'd10; def = 8'd2; mon_hp = 8'd25; mon_atk = 8'd7; mon_def = 8'd4;
  endtask

  // Pass-through result for the current stimulus; tests override fields.
  function automatic exp_t base(input string tag);
    exp_t e;
    e.tag = tag; e.blocked = 1'b0; e.gx = pos_x; e.gy = pos_y;
    e.fl = floor; e.keys = key_num; e.hp = health; e.tile = tile_id;
    e.lat = 2; e.start = 0;
    return e;
  endfunction

  function automatic exp_t refused(input exp_t e);
    exp_t r;
    r = e; r.blocked = 1'b1; r.gx = player_x; r.gy = player_y;
    return r;
  endfunction

  task automatic handshake();
    int t;
    @(negedge clk);
    req_valid = 1'b1;
    t = 0;
    while (req_ready !== 1'b1 && t < 50) begin @(negedge clk); t++; end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic send(input exp_t e);
    int t;
    handshake();
    e.start = cyc;
    q.push_back(e);
    t = 0;
    while (q.size() != 0 && t < 600) begin @(negedge clk); t++; end
    if (q.size() != 0) begin
      check({e.tag, ".timeout"}, 64'd1, 64'd0);
      q.delete();
    end
  endtask

  task automatic check_cleared(input string tag);
    check({tag, ".req_ready"}, 64'(req_ready), 64'd1);
    check({tag, ".res_valid"}, 64'(res_valid), 64'd0);
    check({tag, ".blocked"},   64'(blocked), 64'd0);
    check({tag, ".goto"},      64'({goto_x, goto_y}), 64'd0);
    check({tag, ".floor"},     64'(floor_out), 64'd0);
    check({tag, ".keys"},      64'(key_num_out), 64'd0);
    check({tag, ".health"},    64'(health_out), 64'd0);
    check({tag, ".tile"},      64'(new_tile_id), 64'd0);
  endtask

  initial begin
    exp_t e;
    set_defaults();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;
    @(negedge clk);
    check("reset_release.req_ready", 64'(req_ready), 64'd1);

    tile_id = 16'h0022; key_num = 32'h00FF_0000;
    e = base("key2_sat"); e.tile = 16'h0000; send(e);
    tile_id = 16'h0052;
    e = base("door2"); e.keys = 32'h00FE_0000; e.tile = 16'h0000; send(e);
    tile_id = 16'h0051; key_num = 32'h0;
    e = refused(base("door1_nokey")); send(e);
    tile_id = 16'h0020; key_num = 32'h1122_3303;
    e = base("key0"); e.keys = 32'h1122_3304; e.tile = 16'h0000; send(e);

    set_defaults();
    tile_id = 16'h0030; health = 16'hFFFD;
    e = base("potion_sat"); e.hp = 16'hFFFF; e.tile = 16'h0000; send(e);
    tile_id = 16'h0040; health = 16'd100;
    e = base("gem"); e.hp = 16'd105; e.tile = 16'h0000; send(e);
    tile_id = 16'h0061; floor = 16'd0;
    e = refused(base("down_floor0")); send(e);
    tile_id = 16'h0060; floor = 16'd3;
    e = base("up_floor3"); e.fl = 16'd4; e.gx = 4'd1; e.gy = 4'd2; send(e);
    tile_id = 16'h0061;
    e = base("down_floor3"); e.fl = 16'd2; e.gx = 4'd3; e.gy = 4'd4; send(e);
    tile_id = 16'h0060; floor = 16'hFFFF;
    e = refused(base("up_top")); send(e);
    set_defaults();
    tile_id = 16'h0010;
    e = refused(base("wall")); send(e);
    tile_id = 16'h0005;
    e = base("other"); send(e);

    set_defaults();
    tile_id = 16'h0100;
`ifdef INTERACT_COMBAT_EN
    e = base("fight_win"); e.hp = 16'd80; e.tile = 16'h0000; e.lat = 7; send(e);
    atk = 8'd4;
    e = refused(base("fight_nodmg")); send(e);
    atk = 8'd10; health = 16'd10; mon_hp = 8'd13;
    e = refused(base("fight_lose")); e.lat = 4; send(e);
`else
    e = base("monster_cost"); e.hp = 16'd97; e.tile = 16'h0000; send(e);
    health = 16'd3;
    e = refused(base("monster_weak")); send(e);
`endif

    // Abort mid-operation: no result, everything cleared.
    set_defaults();
    tile_id = 16'h0100;
    handshake();
`ifdef INTERACT_COMBAT_EN
    repeat (2) @(posedge clk);
`else
    repeat (1) @(posedge clk);
`endif
    #1 rst = 1'b1;
    #1 check_cleared("abort");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("abort.no_result", 64'(q.size()), 64'd0);
    tile_id = 16'h0010;
    e = refused(base("wall_after_abort")); send(e);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
